// File: rtl/arm7tdmi_pkg.sv
// rtl/arm7tdmi_pkg.sv - shared types and constants for the arm7tdmi bus slice
package arm7tdmi_pkg;

   typedef enum logic {MR_IDLE, MR_WAIT} mem_resp_state_t;

   localparam logic [31:0] ARM_NOP       = 32'hE1A00000;
   localparam logic [31:0] MEM_ERR_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/arm_mem_responder.sv
// rtl/arm_mem_responder.sv - word RAM responder with byte-enable writes, wait states and preload
module arm_mem_responder
   import arm7tdmi_pkg::*;
#(
   parameter int unsigned  DEPTH_WORDS = 1024,
   parameter logic [31:0]  INIT_WORD   = ARM_NOP,
   parameter logic [31:0]  ERR_RDATA   = MEM_ERR_RDATA
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic        mem_we,
   input  logic        mem_re,
   input  logic [3:0]  mem_be,
   output logic [31:0] mem_rdata,
   output logic        mem_ready,
   output logic        mem_err,
   input  logic [3:0]  wait_cfg,
   input  logic        load_en,
   input  logic [31:0] load_addr,
   input  logic [31:0] load_data,
   output logic [31:0] rd_count,
   output logic [31:0] wr_count
);

   localparam int AW = $clog2(DEPTH_WORDS);

   if ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_depth_check
      $error("arm_mem_responder: DEPTH_WORDS must be a power of two");
   end

   logic [31:0] ram [DEPTH_WORDS] = '{default: INIT_WORD};

   mem_resp_state_t state, state_next;
   logic [3:0]      cnt, cnt_next;

   logic          req, done, bus_oor, load_oor, bus_wr;
   logic [AW-1:0] bus_idx, load_idx;
   logic [31:0]   merged;
   logic          unused_addr_bits;

   assign req      = mem_re | mem_we;
   assign done     = mem_ready & req;
   assign bus_idx  = mem_addr[AW+1:2];
   assign load_idx = load_addr[AW+1:2];
   assign bus_oor  = |mem_addr[31:AW+2];
   assign load_oor = |load_addr[31:AW+2];
   assign unused_addr_bits = ^{mem_addr[1:0], load_addr[1:0]};

   // Reset aborts any completing write so a mid-WAIT reset leaves RAM untouched.
   assign bus_wr   = done & mem_we & ~bus_oor & ~rst;

   assign mem_err   = done & bus_oor;
   assign mem_rdata = bus_oor ? ERR_RDATA : ram[bus_idx];

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= MR_IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      mem_ready  = 1'b0;
      case (state)
         MR_IDLE: begin
            if (wait_cfg == 4'd0) begin
               mem_ready = 1'b1;
            end else if (req) begin
               state_next = MR_WAIT;
               cnt_next   = wait_cfg - 4'd1;
            end
         end
         MR_WAIT: begin
            mem_ready = (cnt == 4'd0);
            if (!req || cnt == 4'd0) begin
               state_next = MR_IDLE;
            end else begin
               cnt_next = cnt - 4'd1;
            end
         end
         default: state_next = MR_IDLE;
      endcase
   end

   for (genvar i = 0; i < 4; i++) begin : g_lane
      assign merged[8*i +: 8] = mem_be[i] ? mem_wdata[8*i +: 8] : ram[bus_idx][8*i +: 8];
   end

   // Bus write is issued last so it wins over a same-word backdoor load.
   always_ff @(posedge clk) begin
      if (load_en && !load_oor) begin
         ram[load_idx] <= load_data;
      end
      if (bus_wr) begin
         ram[bus_idx] <= merged;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_count <= 32'd0;
         wr_count <= 32'd0;
      end else if (done) begin
         if (mem_we) begin
            wr_count <= wr_count + 32'd1;
         end else begin
            rd_count <= rd_count + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_arm_mem_responder.sv
// tb/tb_arm_mem_responder.sv - directed self-checking bench for arm_mem_responder
module tb_arm_mem_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] mem_addr = 32'd0;
   logic [31:0] mem_wdata = 32'd0;
   logic        mem_we = 1'b0;
   logic        mem_re = 1'b0;
   logic [3:0]  mem_be = 4'd0;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        mem_err;
   logic [3:0]  wait_cfg = 4'd0;
   logic        load_en = 1'b0;
   logic [31:0] load_addr = 32'd0;
   logic [31:0] load_data = 32'd0;
   logic [31:0] rd_count;
   logic [31:0] wr_count;

   int n_checks = 0;
   int n_fail   = 0;

   arm_mem_responder #(.DEPTH_WORDS(1024)) dut (
      .clk       (clk),
      .rst       (rst),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_re    (mem_re),
      .mem_be    (mem_be),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .mem_err   (mem_err),
      .wait_cfg  (wait_cfg),
      .load_en   (load_en),
      .load_addr (load_addr),
      .load_data (load_data),
      .rd_count  (rd_count),
      .wr_count  (wr_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      mem_addr = 32'h10;
      tick();
      tick();
      n_checks++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %h want 1", mem_ready); end
      n_checks++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %h want 0", mem_err); end
      n_checks++; if (rd_count !== 32'd0 || wr_count !== 32'd0) begin n_fail++; $display("FAIL reset_counts got %h/%h want 0/0", rd_count, wr_count); end
      rst = 1'b0;
   endtask

   task automatic test_zero_wait_read();
      mem_re = 1'b1;
      mem_addr = 32'h10;
      #1;
      n_checks++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL zw_ready got %h want 1", mem_ready); end
      n_checks++; if (mem_rdata !== 32'hE1A00000) begin n_fail++; $display("FAIL zw_rdata got %h want e1a00000", mem_rdata); end
      tick();
      mem_re = 1'b0;
      n_checks++; if (rd_count !== 32'd1) begin n_fail++; $display("FAIL zw_rd_count got %0d want 1", rd_count); end
   endtask

   task automatic test_wait_write();
      logic [3:0] ready_seq;
      load_en = 1'b1; load_addr = 32'h20; load_data = 32'hAABBCCDD;
      tick();
      load_en = 1'b0;
      wait_cfg = 4'd3;
      mem_we = 1'b1; mem_addr = 32'h20; mem_be = 4'b0101; mem_wdata = 32'h11223344;
      for (int c = 0; c < 4; c++) begin
         #1;
         ready_seq[c] = mem_ready;
         tick();
      end
      mem_we = 1'b0;
      n_checks++; if (ready_seq !== 4'b1000) begin n_fail++; $display("FAIL ws_ready_seq got %b want 1000", ready_seq); end
      n_checks++; if (wr_count !== 32'd1) begin n_fail++; $display("FAIL ws_wr_count got %0d want 1", wr_count); end
      wait_cfg = 4'd0;
      mem_re = 1'b1;
      #1;
      n_checks++; if (mem_rdata !== 32'hAA22CC44) begin n_fail++; $display("FAIL ws_merge got %h want aa22cc44", mem_rdata); end
      mem_re = 1'b0;
   endtask

   task automatic test_drop_request();
      int lat;
      wait_cfg = 4'd2;
      mem_re = 1'b1; mem_addr = 32'h10;
      tick();
      mem_re = 1'b0;
      tick();
      n_checks++; if (rd_count !== 32'd1) begin n_fail++; $display("FAIL drop_rd_count got %0d want 1", rd_count); end
      mem_re = 1'b1;
      lat = 0;
      #1;
      while (mem_ready !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL drop_latency got %0d low cycles want 2", lat); end
      tick();
      mem_re = 1'b0;
      n_checks++; if (rd_count !== 32'd2) begin n_fail++; $display("FAIL drop_rd_after got %0d want 2", rd_count); end
      wait_cfg = 4'd0;
   endtask

   task automatic test_out_of_range();
      mem_re = 1'b1; mem_addr = 32'h1000;
      #1;
      n_checks++; if (mem_ready !== 1'b1 || mem_err !== 1'b1) begin n_fail++; $display("FAIL oor_rd_flags got ready=%h err=%h want 1/1", mem_ready, mem_err); end
      n_checks++; if (mem_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL oor_rdata got %h want deadbeef", mem_rdata); end
      tick();
      mem_re = 1'b0;
      mem_we = 1'b1; mem_be = 4'hF; mem_wdata = 32'h01234567;
      #1;
      n_checks++; if (mem_err !== 1'b1) begin n_fail++; $display("FAIL oor_wr_err got %h want 1", mem_err); end
      tick();
      mem_we = 1'b0;
      n_checks++; if (rd_count !== 32'd3 || wr_count !== 32'd2) begin n_fail++; $display("FAIL oor_counts got %0d/%0d want 3/2", rd_count, wr_count); end
      mem_re = 1'b1; mem_addr = 32'h0;
      #1;
      n_checks++; if (mem_rdata !== 32'hE1A00000 || mem_err !== 1'b0) begin n_fail++; $display("FAIL oor_alias got %h err=%h want e1a00000 err=0", mem_rdata, mem_err); end
      mem_re = 1'b0;
   endtask

   task automatic test_load_collision();
      load_en = 1'b1; load_addr = 32'h40; load_data = 32'h12345678;
      mem_we = 1'b1; mem_addr = 32'h40; mem_be = 4'hF; mem_wdata = 32'hCAFEF00D;
      tick();
      load_addr = 32'h44;
      mem_we = 1'b0;
      tick();
      load_en = 1'b0;
      mem_re = 1'b1; mem_addr = 32'h40;
      #1;
      n_checks++; if (mem_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL coll_rdata got %h want cafef00d", mem_rdata); end
      mem_addr = 32'h44;
      #1;
      n_checks++; if (mem_rdata !== 32'h12345678) begin n_fail++; $display("FAIL load_only got %h want 12345678", mem_rdata); end
      mem_re = 1'b0;
      mem_we = 1'b1; mem_be = 4'h0; mem_wdata = 32'hFFFFFFFF;
      tick();
      mem_we = 1'b0;
      mem_re = 1'b1;
      #1;
      n_checks++; if (mem_rdata !== 32'h12345678) begin n_fail++; $display("FAIL be0_rdata got %h want 12345678", mem_rdata); end
      mem_re = 1'b0;
      n_checks++; if (wr_count !== 32'd4) begin n_fail++; $display("FAIL be0_wr_count got %0d want 4", wr_count); end
   endtask

   task automatic test_rw_priority();
      mem_re = 1'b1; mem_we = 1'b1; mem_addr = 32'h4C; mem_be = 4'hF; mem_wdata = 32'h0BADF00D;
      tick();
      mem_we = 1'b0;
      #1;
      n_checks++; if (rd_count !== 32'd3 || wr_count !== 32'd5) begin n_fail++; $display("FAIL rw_counts got %0d/%0d want 3/5", rd_count, wr_count); end
      n_checks++; if (mem_rdata !== 32'h0BADF00D) begin n_fail++; $display("FAIL rw_rdata got %h want 0badf00d", mem_rdata); end
      mem_re = 1'b0;
   endtask

   task automatic test_reset_mid_wait();
      wait_cfg = 4'd5;
      mem_we = 1'b1; mem_addr = 32'h48; mem_be = 4'hF; mem_wdata = 32'h55555555;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      mem_we = 1'b0;
      wait_cfg = 4'd0;
      #1;
      n_checks++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL rstw_ready got %h want 1", mem_ready); end
      n_checks++; if (rd_count !== 32'd0 || wr_count !== 32'd0) begin n_fail++; $display("FAIL rstw_counts got %0d/%0d want 0/0", rd_count, wr_count); end
      tick();
      tick();
      tick();
      tick();
      mem_re = 1'b1;
      #1;
      n_checks++; if (mem_rdata !== 32'hE1A00000) begin n_fail++; $display("FAIL rstw_word got %h want e1a00000", mem_rdata); end
      mem_re = 1'b0;
   endtask

   initial begin
      test_reset();
      test_zero_wait_read();
      test_wait_write();
      test_drop_request();
      test_out_of_range();
      test_load_collision();
      test_rw_priority();
      test_reset_mid_wait();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
